mem_ioctrl: RTL and testbench
=============================

Name: mem_ioctrl

Overview:
Memory/IO controller on the memory-side port of the instruction/data arbiter. It takes single-cycle read/write pulses, decodes the address into on-chip SRAM or a small MMIO register bank, and sequences the SRAM with a configurable number of wait-states. Every accepted request returns exactly one single-cycle mem_ack.

Parameters:
ADDR_W, 12, SRAM word-address width (SRAM size is 2^ADDR_W 32-bit words)
WAIT_STATES, 1, extra SRAM cycles inserted between strobe and data capture (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
mem_read  input  1  one-cycle read request pulse
mem_write  input  1  one-cycle write request pulse
mem_addr  input  32  byte address, valid in the request cycle
mem_data_write  input  32  write data, valid in the request cycle
mem_ack  output  1  one-cycle completion pulse
mem_data_read  output  32  read data, valid in the mem_ack cycle
sram_ce  output  1  SRAM chip enable strobe
sram_we  output  1  SRAM write enable, qualified by sram_ce
sram_addr  output  ADDR_W  SRAM word address
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid one cycle after a read strobe
leds  output  8  LED register
err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state=IDLE; mem_ack=0; mem_data_read=0; sram_ce=0; sram_we=0; sram_addr=0; sram_wdata=0; leds=0; err=0; scratch=0; cycle counter=0. An in-flight request is dropped and no ack is issued.
- Address map, using the word index mem_addr[31:2]; bits [1:0] are ignored:
  - RAM: mem_addr[31]=0 and mem_addr[30:ADDR_W+2]=0. sram_addr = mem_addr[ADDR_W+1:2].
  - IO: mem_addr[31:4]=0x8000000. Offsets:
    - +0x0 LED: RW, bits [7:0]; reads zero-extend.
    - +0x4 CYCLE: RO; writes are ignored.
    - +0x8 SCRATCH: RW, 32 bits.
    - +0xC STATUS: bit0 reads err; writing 1 to bit0 clears err.
  - Any other address is unmapped.
- CYCLE: free-running 32-bit up-counter, +1 every clock, wraps 0xFFFFFFFF to 0. A read returns the value in the capture cycle.
- States:
  - IDLE: samples requests.
  - RAM_STROBE: sram_ce=1 for exactly one cycle; sram_we=1 for writes, with captured addr/data.
  - RAM_WAIT: 4-bit counter loaded with WAIT_STATES, decrements to 0; skipped when WAIT_STATES=0.
  - RESP: mem_ack=1 for one cycle; returns to IDLE.
- Latency, with the request pulse at cycle T:
  - RAM: strobe at T+1, ack at T+2+WAIT_STATES. Read data is sram_rdata registered on the last wait cycle (or on the strobe+1 edge when WAIT_STATES=0).
  - IO and unmapped: ack at T+1. An IO write takes effect at the T+1 edge.
- mem_data_read is updated only when an ack is issued for a read. It holds its value otherwise; a write ack leaves it unchanged.
- Unmapped access: still acked at T+1; a read returns 0; sets err.
- mem_read and mem_write in the same cycle: treated as a write; sets err.
- Request while not in IDLE: ignored (no extra ack); sets err.
- An err set event and a STATUS clear in the same cycle: set wins.
- sram_ce/sram_we are 0 in every state except RAM_STROBE.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE, RAM_STROBE, RAM_WAIT, RESP);
  - IO_BASE=0x8000_0000;
  - offset constants LED=0x0, CYCLE=0x4, SCRATCH=0x8, STATUS=0xC.
- One natural sub-module: mem_ioctrl_regs, holding the LED, SCRATCH, CYCLE and STATUS registers with write strobe, offset and read mux. Decode and FSM stay in the top.

Test Plan:
- RAM write then read, WAIT_STATES=1:
  - Write 0xCAFEBABE to 0x0000_0010 -> strobe sram_addr=4, sram_we=1 at T+1; ack at T+3.
  - Read 0x0000_0010 -> ack at T+3 with mem_data_read=0xCAFEBABE.
- WAIT_STATES=0 and WAIT_STATES=15: RAM read -> ack at T+2 and T+17 respectively; exactly one sram_ce pulse each.
- IO accesses:
  - Write 0x1A5 to 0x8000_0000 -> leds=0xA5 after T+1, ack at T+1; read back returns 0x0000_00A5.
  - Two CYCLE reads N cycles apart differ by N.
  - SCRATCH write/read of 0xFFFFFFFF round-trips.
- Errors:
  - Read 0x4000_0000 -> ack at T+1, data 0, err=1.
  - Write 1 to 0x8000_000C -> err=0.
  - Simultaneous read+write to SCRATCH -> write applied, err=1.
- Busy request: second pulse during RAM_WAIT -> ignored, exactly one ack, err=1. Force CYCLE to 0xFFFFFFFF -> next value is 0.
- Reset mid-operation: assert reset during RAM_WAIT -> all outputs return to reset values immediately; no ack after release; next request completes normally.

Source files
------------

// File: rtl/mem_ioctrl_pkg.sv
// Shared encodings and IO address map for the memory/IO controller.
// Pure constants/types; no latency or flow-control implications.
package mem_ioctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RAM_STROBE = 2'd1,
        ST_RAM_WAIT   = 2'd2,
        ST_RESP       = 2'd3
    } state_t;

    localparam logic [31:0] IO_BASE     = 32'h8000_0000;
    localparam logic [3:0]  OFS_LED     = 4'h0;
    localparam logic [3:0]  OFS_CYCLE   = 4'h4;
    localparam logic [3:0]  OFS_SCRATCH = 4'h8;
    localparam logic [3:0]  OFS_STATUS  = 4'hC;

    // Caller passes addr[31:4]; the IO bank is one 16-byte window.
    function automatic logic is_io_addr(input logic [27:0] addr_hi);
        return addr_hi == IO_BASE[31:4];
    endfunction

endpackage

// File: rtl/mem_ioctrl_if.sv
// Pulse-request memory port between the arbiter and the controller.
// One request pulse in, one mem_ack pulse out; no ready, so the master must wait for ack.
interface mem_ioctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_write;
    logic        mem_ack;
    logic [31:0] mem_data_read;

    modport master (
        output mem_read, mem_write, mem_addr, mem_data_write,
        input  mem_ack, mem_data_read
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_data_write,
        output mem_ack, mem_data_read
    );
endinterface

// File: rtl/mem_ioctrl_regs.sv
// MMIO bank: LED, free-running CYCLE counter, SCRATCH and sticky STATUS error flag.
// Writes land on the strobe edge; read mux is combinational; never stalls.
module mem_ioctrl_regs
    import mem_ioctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  ofs,
    input  logic [31:0] wdata,
    input  logic        err_set,
    output logic [31:0] rdata,
    output logic [7:0]  leds,
    output logic        err
);
    logic [31:0] cycle_cnt;
    logic [31:0] scratch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            scratch   <= '0;
            leds      <= '0;
            err       <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_en && ofs == OFS_LED)     leds    <= wdata[7:0];
            if (wr_en && ofs == OFS_SCRATCH) scratch <= wdata;
            // A new error in the same cycle as a clear must not be lost.
            if (err_set)                                       err <= 1'b1;
            else if (wr_en && ofs == OFS_STATUS && wdata[0])   err <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_LED:     rdata = {24'd0, leds};
            OFS_CYCLE:   rdata = cycle_cnt;
            OFS_SCRATCH: rdata = scratch;
            OFS_STATUS:  rdata = {31'd0, err};
            default:     rdata = '0;
        endcase
    end
endmodule

// File: rtl/mem_ioctrl.sv
// Decodes pulse requests to SRAM or MMIO and sequences SRAM with WAIT_STATES extra cycles.
// Ack at T+1 for IO/unmapped, T+2+WAIT_STATES for SRAM; requests while busy are dropped and flag err.
module mem_ioctrl
    import mem_ioctrl_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_ioctrl_if.slave       bus,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [7:0]        leds,
    output logic              err
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state, state_nx;
    logic [3:0]  wait_cnt;
    logic        wr_q;
    logic        req, is_ram, is_io;
    logic        accept, ram_last, ack;
    logic        err_set, reg_wr;
    logic [31:0] reg_rdata, rdata_q;
    logic        unused_addr_lsb;

    assign req             = bus.mem_read | bus.mem_write;
    assign is_ram          = !bus.mem_addr[31] && (bus.mem_addr[30:ADDR_W+2] == '0);
    assign is_io           = is_io_addr(bus.mem_addr[31:4]);
    assign unused_addr_lsb = ^bus.mem_addr[1:0];
    assign bus.mem_ack     = ack;
    assign bus.mem_data_read = rdata_q;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        ack      = 1'b0;
        sram_ce  = 1'b0;
        sram_we  = 1'b0;
        ram_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept   = 1'b1;
                    state_nx = is_ram ? ST_RAM_STROBE : ST_RESP;
                end
            end
            ST_RAM_STROBE: begin
                sram_ce  = 1'b1;
                sram_we  = wr_q;
                ram_last = (WS == 4'd0);
                state_nx = (WS == 4'd0) ? ST_RESP : ST_RAM_WAIT;
            end
            ST_RAM_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    ram_last = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                ack      = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Simultaneous read+write is accepted as a write but still reported.
        err_set = (req && state != ST_IDLE)
               || (accept && ((bus.mem_read && bus.mem_write) || (!is_ram && !is_io)));
        reg_wr  = accept && bus.mem_write && is_io;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= '0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            if (state == ST_RAM_STROBE)    wait_cnt <= WS;
            else if (state == ST_RAM_WAIT) wait_cnt <= wait_cnt - 4'd1;

            if (accept) begin
                wr_q <= bus.mem_write;
                if (is_ram) begin
                    sram_addr  <= bus.mem_addr[ADDR_W+1:2];
                    sram_wdata <= bus.mem_data_write;
                end else if (!bus.mem_write) begin
                    rdata_q <= is_io ? reg_rdata : '0;
                end
            end

            if (ram_last && !wr_q) rdata_q <= sram_rdata;
        end
    end

    mem_ioctrl_regs u_regs (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (reg_wr),
        .ofs     ({bus.mem_addr[3:2], 2'b00}),
        .wdata   (bus.mem_data_write),
        .err_set (err_set),
        .rdata   (reg_rdata),
        .leds    (leds),
        .err     (err)
    );
endmodule

// File: tb/tb_mem_ioctrl.sv
// Bench for mem_ioctrl: three instances (WAIT_STATES 0, 1, 15) with behavioural SRAMs,
// directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_ioctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        t_rd   [3];
    logic        t_wr   [3];
    logic [31:0] t_addr [3];
    logic [31:0] t_wd   [3];
    logic        ack_w  [3];
    logic [31:0] rdat_w [3];
    logic        ce_w   [3];
    logic        we_w   [3];
    logic [11:0] sa_w   [3];
    logic [31:0] swd_w  [3];
    logic [7:0]  leds_w [3];
    logic        err_w  [3];

    int          cyc;
    int          ce_cnt  [3];
    int          st_cyc  [3];
    logic        st_we   [3];
    logic [11:0] st_addr [3];
    logic [31:0] st_wd   [3];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 15);
        mem_ioctrl_if bus ();
        logic        ce, we, err;
        logic [11:0] sa;
        logic [31:0] swd, srd;
        logic [7:0]  leds;
        logic [31:0] sram [4096];

        assign bus.mem_read       = t_rd[g];
        assign bus.mem_write      = t_wr[g];
        assign bus.mem_addr       = t_addr[g];
        assign bus.mem_data_write = t_wd[g];
        assign ack_w[g]  = bus.mem_ack;
        assign rdat_w[g] = bus.mem_data_read;
        assign ce_w[g]   = ce;
        assign we_w[g]   = we;
        assign sa_w[g]   = sa;
        assign swd_w[g]  = swd;
        assign leds_w[g] = leds;
        assign err_w[g]  = err;

        assign srd = sram[sa];
        always @(posedge clk) if (ce && we) sram[sa] <= swd;

        mem_ioctrl #(.ADDR_W(12), .WAIT_STATES(WS)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .bus        (bus),
            .sram_ce    (ce),
            .sram_we    (we),
            .sram_addr  (sa),
            .sram_wdata (swd),
            .sram_rdata (srd),
            .leds       (leds),
            .err        (err)
        );
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (ce_w[i] === 1'b1) begin
                ce_cnt[i]  <= ce_cnt[i] + 1;
                st_cyc[i]  <= cyc;
                st_we[i]   <= we_w[i];
                st_addr[i] <= sa_w[i];
                st_wd[i]   <= swd_w[i];
            end
        end
    end

    // One request pulse, then wait (bounded) for the ack; lat=-1 on timeout.
    task automatic do_req(input int i, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] q, output int t0);
        t_rd[i] = rd; t_wr[i] = wr; t_addr[i] = a; t_wd[i] = d; t0 = cyc;
        @(posedge clk); #1;
        t_rd[i] = 1'b0; t_wr[i] = 1'b0;
        lat = 1; q = '0;
        while (ack_w[i] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (ack_w[i] === 1'b1) q = rdat_w[i];
        else lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ack_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d] got=%b exp=0", i, ack_w[i]); end
            n_checks++; if (rdat_w[i] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d] got=%h exp=0", i, rdat_w[i]); end
            n_checks++; if (ce_w[i] !== 1'b0 || we_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ce_we[%0d] got=%b%b exp=00", i, ce_w[i], we_w[i]); end
            n_checks++; if (sa_w[i] !== 12'd0 || swd_w[i] !== 32'd0) begin n_fail++; $display("FAIL reset_sram_bus[%0d] got=%h/%h exp=0/0", i, sa_w[i], swd_w[i]); end
            n_checks++; if (leds_w[i] !== 8'd0 || err_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_leds_err[%0d] got=%h/%b exp=0/0", i, leds_w[i], err_w[i]); end
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ack_w[1] !== 1'b0 || ce_w[1] !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got=%b%b exp=00", ack_w[1], ce_w[1]); end
    endtask

    task automatic test_ram_ws1;
        int lat, t0, c0;
        logic [31:0] q;
        c0 = ce_cnt[1];
        do_req(1, 1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_BABE, lat, q, t0);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ram_wr_lat got=%0d exp=3", lat); end
        n_checks++; if (st_cyc[1] !== t0 + 1) begin n_fail++; $display("FAIL ram_wr_strobe_cycle got=%0d exp=%0d", st_cyc[1], t0 + 1); end
        n_checks++; if (st_we[1] !== 1'b1 || st_addr[1] !== 12'd4) begin n_fail++; $display("FAIL ram_wr_strobe got we=%b addr=%h exp we=1 addr=004", st_we[1], st_addr[1]); end
        n_checks++; if (st_wd[1] !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL ram_wr_data got=%h exp=cafebabe", st_wd[1]); end
        n_checks++; if (ce_cnt[1] - c0 !== 1) begin n_fail++; $display("FAIL ram_wr_ce_count got=%0d exp=1", ce_cnt[1] - c0); end
        do_req(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, q, t0);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ram_rd_lat got=%0d exp=3", lat); end
        n_checks++; if (q !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL ram_rd_data got=%h exp=cafebabe", q); end
        n_checks++; if (st_we[1] !== 1'b0) begin n_fail++; $display("FAIL ram_rd_we got=%b exp=0", st_we[1]); end
    endtask

    logic [31:0] ws15_word;

    task automatic test_wait_states;
        int lat, t0, c0, i, exp_lat;
        logic [31:0] q, w;
        for (int k = 0; k < 2; k++) begin
            i       = (k == 0) ? 0 : 2;
            exp_lat = (k == 0) ? 2 : 17;
            w       = $urandom;
            if (k == 1) ws15_word = w;
            do_req(i, 1'b0, 1'b1, 32'h0000_0024, w, lat, q, t0);
            c0 = ce_cnt[i];
            do_req(i, 1'b1, 1'b0, 32'h0000_0024, 32'h0, lat, q, t0);
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL ws_rd_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
            n_checks++; if (q !== w) begin n_fail++; $display("FAIL ws_rd_data[%0d] got=%h exp=%h", i, q, w); end
            n_checks++; if (ce_cnt[i] - c0 !== 1) begin n_fail++; $display("FAIL ws_ce_count[%0d] got=%0d exp=1", i, ce_cnt[i] - c0); end
        end
    endtask

    task automatic test_io;
        int lat, t0, t1, n;
        logic [31:0] q, q1;
        do_req(1, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_01A5, lat, q, t0);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL led_wr_lat got=%0d exp=1", lat); end
        n_checks++; if (leds_w[1] !== 8'hA5) begin n_fail++; $display("FAIL led_value got=%h exp=a5", leds_w[1]); end
        do_req(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, q, t0);
        n_checks++; if (lat !== 1 || q !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_readback got lat=%0d data=%h exp lat=1 data=000000a5", lat, q); end
        do_req(1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, lat, q1, t0);
        n = $urandom_range(3, 20);
        repeat (n) begin @(posedge clk); #1; end
        do_req(1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, lat, q, t1);
        n_checks++; if (q - q1 !== 32'(t1 - t0)) begin n_fail++; $display("FAIL cycle_delta got=%0d exp=%0d", q - q1, t1 - t0); end
        do_req(1, 1'b0, 1'b1, 32'h8000_0008, 32'hFFFF_FFFF, lat, q, t0);
        do_req(1, 1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, q, t0);
        n_checks++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL scratch_roundtrip got=%h exp=ffffffff", q); end
    endtask

    task automatic test_errors;
        int lat, t0;
        logic [31:0] q;
        do_req(1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, lat, q, t0);
        n_checks++; if (lat !== 1 || q !== 32'd0) begin n_fail++; $display("FAIL unmapped_rd got lat=%0d data=%h exp lat=1 data=0", lat, q); end
        n_checks++; if (err_w[1] !== 1'b1) begin n_fail++; $display("FAIL unmapped_err got=%b exp=1", err_w[1]); end
        do_req(1, 1'b0, 1'b1, 32'h8000_000C, 32'h1, lat, q, t0);
        n_checks++; if (err_w[1] !== 1'b0) begin n_fail++; $display("FAIL status_clear got=%b exp=0", err_w[1]); end
        do_req(1, 1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, q, t0);
        do_req(1, 1'b1, 1'b1, 32'h8000_0008, 32'h1234_5678, lat, q, t0);
        n_checks++; if (lat !== 1 || q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rdwr_hold_data got lat=%0d data=%h exp lat=1 data=ffffffff", lat, q); end
        n_checks++; if (err_w[1] !== 1'b1) begin n_fail++; $display("FAIL rdwr_err got=%b exp=1", err_w[1]); end
        do_req(1, 1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, q, t0);
        n_checks++; if (q !== 32'h1234_5678) begin n_fail++; $display("FAIL rdwr_applied got=%h exp=12345678", q); end
    endtask

    task automatic test_busy;
        int n_ack, ack_at, lat, t0;
        logic [31:0] q;
        n_ack = 0; ack_at = 0; q = '0;
        t_rd[2] = 1'b1; t_addr[2] = 32'h0000_0024;
        @(posedge clk); #1;
        t_rd[2] = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (ack_w[2] === 1'b1) begin
                n_ack++;
                if (n_ack == 1) begin ack_at = k; q = rdat_w[2]; end
            end
            if (k == 4) begin t_wr[2] = 1'b1; t_addr[2] = 32'h8000_0008; t_wd[2] = 32'hDEAD_BEEF; end
            else t_wr[2] = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++; if (n_ack !== 1) begin n_fail++; $display("FAIL busy_ack_count got=%0d exp=1", n_ack); end
        n_checks++; if (ack_at !== 17 || q !== ws15_word) begin n_fail++; $display("FAIL busy_first_ack got at=%0d data=%h exp at=17 data=%h", ack_at, q, ws15_word); end
        n_checks++; if (err_w[2] !== 1'b1) begin n_fail++; $display("FAIL busy_err got=%b exp=1", err_w[2]); end
        do_req(2, 1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, q, t0);
        n_checks++; if (q !== 32'd0) begin n_fail++; $display("FAIL busy_write_dropped got=%h exp=0", q); end
    endtask

    task automatic test_cycle_wrap;
        int lat, t0, t1;
        logic [31:0] q0, q1, e;
        force g_dut[1].u_dut.u_regs.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release g_dut[1].u_dut.u_regs.cycle_cnt;
        do_req(1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, lat, q0, t0);
        do_req(1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, lat, q1, t1);
        n_checks++; if (q0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_forced got=%h exp=ffffffff", q0); end
        e = 32'hFFFF_FFFF + 32'(t1 - t0);
        n_checks++; if (q1 !== e) begin n_fail++; $display("FAIL cycle_wrap got=%h exp=%h", q1, e); end
    endtask

    task automatic test_reset_mid;
        int lat, t0, n_ack;
        logic [31:0] q;
        do_req(2, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_005A, lat, q, t0);
        do_req(2, 1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, q, t0);
        n_checks++; if (q !== 32'h0000_005A) begin n_fail++; $display("FAIL mid_pre_led got=%h exp=0000005a", q); end
        t_rd[2] = 1'b1; t_addr[2] = 32'h0000_0024;
        @(posedge clk); #1;
        t_rd[2] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        n_checks++; if (ack_w[2] !== 1'b0 || rdat_w[2] !== 32'd0) begin n_fail++; $display("FAIL mid_reset_resp got ack=%b data=%h exp ack=0 data=0", ack_w[2], rdat_w[2]); end
        n_checks++; if (ce_w[2] !== 1'b0 || sa_w[2] !== 12'd0 || swd_w[2] !== 32'd0) begin n_fail++; $display("FAIL mid_reset_sram got ce=%b addr=%h wd=%h exp 0", ce_w[2], sa_w[2], swd_w[2]); end
        n_checks++; if (leds_w[2] !== 8'd0 || err_w[2] !== 1'b0 || leds_w[1] !== 8'd0) begin n_fail++; $display("FAIL mid_reset_regs got leds=%h err=%b leds1=%h exp 0", leds_w[2], err_w[2], leds_w[1]); end
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        n_ack = 0;
        repeat (25) begin
            if (ack_w[2] === 1'b1) n_ack++;
            @(posedge clk); #1;
        end
        n_checks++; if (n_ack !== 0) begin n_fail++; $display("FAIL mid_no_stale_ack got=%0d exp=0", n_ack); end
        do_req(2, 1'b1, 1'b0, 32'h0000_0024, 32'h0, lat, q, t0);
        n_checks++; if (lat !== 17 || q !== ws15_word) begin n_fail++; $display("FAIL mid_recover got lat=%0d data=%h exp lat=17 data=%h", lat, q, ws15_word); end
    endtask

    // Transaction-level model: RAM words, LED/SCRATCH/err state, last read data.
    task automatic test_random;
        logic [31:0] ram_m [8];
        logic [7:0]  leds_m;
        logic [31:0] scratch_m, data_m, a, d, q, exp_q;
        logic        err_m, rd, both;
        int          op, w, lat, t0, exp_lat;
        leds_m = 8'd0; scratch_m = '0; err_m = 1'b0;
        data_m = ws15_word & 32'h0;
        data_m = 32'd0;
        do_req(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, q, t0);
        for (int k = 0; k < 8; k++) begin
            ram_m[k] = $urandom;
            do_req(1, 1'b0, 1'b1, 32'h0000_0100 + 32'(k * 4), ram_m[k], lat, q, t0);
            n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rnd_fill_lat[%0d] got=%0d exp=3", k, lat); end
        end
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 5); rd = 1'($urandom_range(0, 1)); d = $urandom;
            both = 1'b0; exp_lat = 1; exp_q = 32'd0;
            w = $urandom_range(0, 7);
            a = 32'($urandom_range(0, 3));
            case (op)
                0: begin
                    a = a + 32'h0000_0100 + 32'(w * 4); exp_lat = 3;
                    if (rd) exp_q = ram_m[w]; else ram_m[w] = d;
                end
                1: begin
                    a = a | 32'h8000_0000;
                    if (rd) exp_q = {24'd0, leds_m}; else leds_m = d[7:0];
                end
                2: begin a = a | 32'h8000_0004; rd = 1'b0; end
                3: begin
                    a = a | 32'h8000_0008;
                    if (!rd && $urandom_range(0, 3) == 0) begin both = 1'b1; err_m = 1'b1; end
                    if (rd) exp_q = scratch_m; else scratch_m = d;
                end
                4: begin
                    a = a | 32'h8000_000C;
                    if (rd) exp_q = {31'd0, err_m}; else if (d[0]) err_m = 1'b0;
                end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? (32'h4000_0000 | ($urandom & 32'h3FFF_FFFC))
                                                    : (32'h8000_0010 + ($urandom & 32'h0000_0FF0));
                    err_m = 1'b1;
                end
            endcase
            if (rd) data_m = exp_q;
            do_req(1, rd || both, !rd || both, a, d, lat, q, t0);
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d] op=%0d addr=%h got=%0d exp=%0d", n, op, a, lat, exp_lat); end
            n_checks++; if (q !== data_m) begin n_fail++; $display("FAIL rnd_data[%0d] op=%0d addr=%h got=%h exp=%h", n, op, a, q, data_m); end
            n_checks++; if (err_w[1] !== err_m) begin n_fail++; $display("FAIL rnd_err[%0d] op=%0d got=%b exp=%b", n, op, err_w[1], err_m); end
            n_checks++; if (leds_w[1] !== leds_m) begin n_fail++; $display("FAIL rnd_leds[%0d] op=%0d got=%h exp=%h", n, op, leds_w[1], leds_m); end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            t_rd[i] = 1'b0; t_wr[i] = 1'b0; t_addr[i] = '0; t_wd[i] = '0;
        end
        n_checks = 0;
        n_fail   = 0;
        ws15_word = '0;
        test_reset;
        test_ram_ws1;
        test_wait_states;
        test_io;
        test_errors;
        test_busy;
        test_cycle_wrap;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
